// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned N_REQ        = 8;
    localparam int unsigned IDX_W        = 3;
    localparam int unsigned HOLD_W       = 8;
    localparam int unsigned DEF_MAX_HOLD = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COOL  = 2'd2
    } state_t;

    // First set request searching upward from ptr+1; ptr itself is checked last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        pick = ptr;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                pick = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/onehot_dec3.sv
// 3-bit binary to 8-bit one-hot decoder with enable gating.
module onehot_dec3
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] oh_c
);

    always_comb begin
        oh_c = '0;
        if (en) begin
            oh_c[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb_8.sv
// 8-requester round-robin arbiter with IDLE/GRANT/COOL handshake.
// Optional forced release after MAX_HOLD cycles when RR_ARB_TIMEOUT_EN is defined.
module rr_arb_8
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic             grant_vld,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N_REQ-1:0] grant_oh,
    output logic             timeout
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arb_8: MAX_HOLD must be in 1..255");
    end

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             vld_nxt;
    logic             timeout_nxt;
    logic             release_c;
    logic             hold_hit_c;
    logic [N_REQ-1:0] oh_nxt_c;

    assign release_c = done | ~req[grant_idx];

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt;

    // Counts cycles spent in GRANT; sits at zero in every other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state == GRANT) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end else begin
            hold_cnt <= '0;
        end
    end

    assign hold_hit_c = (hold_cnt == HOLD_LAST);
`else
    assign hold_hit_c = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        idx_nxt     = grant_idx;
        vld_nxt     = 1'b0;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                    idx_nxt   = rr_pick(req, ptr);
                    vld_nxt   = 1'b1;
                end
            end
            GRANT: begin
                // A normal release wins over a coincident hold expiry.
                if (release_c) begin
                    state_nxt = COOL;
                    ptr_nxt   = grant_idx;
                end else if (hold_hit_c) begin
                    state_nxt   = COOL;
                    ptr_nxt     = grant_idx;
                    timeout_nxt = 1'b1;
                end else begin
                    vld_nxt = 1'b1;
                end
            end
            COOL: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    onehot_dec3 u_dec (
        .idx  (idx_nxt),
        .en   (vld_nxt),
        .oh_c (oh_nxt_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= IDX_W'(N_REQ - 1);
            grant_vld <= 1'b0;
            grant_idx <= '0;
            grant_oh  <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            grant_vld <= vld_nxt;
            grant_idx <= idx_nxt;
            grant_oh  <= oh_nxt_c;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arb_8.sv
// Self-checking bench for rr_arb_8: directed table, corner sequences, random vs model.
module tb_rr_arb_8;

    localparam int unsigned MAXH = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       grant_vld;
    logic [2:0] grant_idx;
    logic [7:0] grant_oh;
    logic       timeout;

    int nchk;
    int nerr;

    rr_arb_8 #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx),
        .grant_oh  (grant_oh),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference model: owner, last owner, cooldown flag, cycles held
    bit m_vld;
    int m_idx;
    int m_last;
    bit m_cool;
    int m_held;
    bit m_to;

    function automatic int rr_next(input logic [7:0] r, input int last);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = 99;
        for (int k = 0; k < 8; k++) begin
            if (r[k]) begin
                d = (k - last - 1 + 16) % 8;
                if (d < bestd) begin
                    bestd = d;
                    best  = k;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_vld  = 1'b0;
        m_idx  = 0;
        m_last = 7;
        m_cool = 1'b0;
        m_held = 0;
        m_to   = 1'b0;
    endtask

    task automatic model_step();
        m_to = 1'b0;
        if (m_vld) begin
            if (done || !req[m_idx]) begin
                m_vld  = 1'b0;
                m_cool = 1'b1;
                m_last = m_idx;
            end else if (TO_EN && (m_held + 1 >= int'(MAXH))) begin
                m_vld  = 1'b0;
                m_cool = 1'b1;
                m_last = m_idx;
                m_to   = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else if (req != 8'h00) begin
            m_idx  = rr_next(req, m_last);
            m_vld  = 1'b1;
            m_held = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string name);
        logic [7:0] eoh;
        eoh = m_vld ? (8'h01 << m_idx) : 8'h00;
        chk({name, ".vld"}, 32'(grant_vld), 32'(m_vld));
        chk({name, ".idx"}, 32'(grant_idx), 32'(m_idx));
        chk({name, ".oh"},  32'(grant_oh),  32'(eoh));
        chk({name, ".to"},  32'(timeout),   32'(m_to));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic       vld;
        logic [2:0] idx;
        logic [7:0] oh;
    } vec_t;

    vec_t vt[18];

    initial begin
        logic [9:0] pat_vld;
        logic [9:0] pat_to;
        int         exp_owner;
        int         grants;
        int         gcyc;
        int         zrun;
        bit         prev_vld;

        nchk = 0;
        nerr = 0;

        vt[0]  = '{8'h05, 1'b0, 1'b1, 3'd0, 8'h01};
        vt[1]  = '{8'h05, 1'b0, 1'b1, 3'd0, 8'h01};
        vt[2]  = '{8'h05, 1'b1, 1'b0, 3'd0, 8'h00};
        vt[3]  = '{8'h05, 1'b0, 1'b0, 3'd0, 8'h00};
        vt[4]  = '{8'h05, 1'b0, 1'b1, 3'd2, 8'h04};
        vt[5]  = '{8'h24, 1'b0, 1'b1, 3'd2, 8'h04};
        vt[6]  = '{8'h20, 1'b0, 1'b0, 3'd2, 8'h00};
        vt[7]  = '{8'h20, 1'b1, 1'b0, 3'd2, 8'h00};
        vt[8]  = '{8'h20, 1'b1, 1'b1, 3'd5, 8'h20};
        vt[9]  = '{8'h28, 1'b0, 1'b1, 3'd5, 8'h20};
        vt[10] = '{8'h08, 1'b0, 1'b0, 3'd5, 8'h00};
        vt[11] = '{8'h08, 1'b0, 1'b0, 3'd5, 8'h00};
        vt[12] = '{8'h08, 1'b0, 1'b1, 3'd3, 8'h08};
        vt[13] = '{8'h00, 1'b1, 1'b0, 3'd3, 8'h00};
        vt[14] = '{8'h00, 1'b0, 1'b0, 3'd3, 8'h00};
        vt[15] = '{8'h00, 1'b0, 1'b0, 3'd3, 8'h00};
        vt[16] = '{8'h08, 1'b0, 1'b1, 3'd3, 8'h08};
        vt[17] = '{8'h08, 1'b1, 1'b0, 3'd3, 8'h00};

        // Reset state
        do_reset();
        chk("rst.vld", 32'(grant_vld), 32'd0);
        chk("rst.idx", 32'(grant_idx), 32'd0);
        chk("rst.oh",  32'(grant_oh),  32'd0);
        chk("rst.to",  32'(timeout),   32'd0);

        // Directed table
        for (int i = 0; i < 18; i++) begin
            req  = vt[i].req;
            done = vt[i].done;
            tick();
            chk($sformatf("tab%0d.vld", i), 32'(grant_vld), 32'(vt[i].vld));
            chk($sformatf("tab%0d.idx", i), 32'(grant_idx), 32'(vt[i].idx));
            chk($sformatf("tab%0d.oh", i),  32'(grant_oh),  32'(vt[i].oh));
            chk($sformatf("tab%0d.to", i),  32'(timeout),   32'd0);
        end

        // All requesting, done on each 3rd grant cycle: owners 0..7,0 with 2-cycle gaps
        do_reset();
        req       = 8'hFF;
        exp_owner = 0;
        grants    = 0;
        gcyc      = 0;
        zrun      = 0;
        prev_vld  = 1'b0;
        for (int c = 0; c < 200 && grants < 9; c++) begin
            tick();
            if (grant_vld) begin
                if (!prev_vld) begin
                    chk($sformatf("rr.owner%0d", grants), 32'(grant_idx), 32'(exp_owner % 8));
                    if (grants > 0) chk($sformatf("rr.gap%0d", grants), 32'(zrun), 32'd2);
                    grants++;
                    exp_owner++;
                    gcyc = 1;
                end else begin
                    gcyc++;
                end
                zrun = 0;
            end else begin
                zrun++;
            end
            prev_vld = grant_vld;
            done = grant_vld && (gcyc == 3);
        end
        chk("rr.grants", 32'(grants), 32'd9);
        done = 1'b0;

        // Reset mid-grant drops outputs without a clock edge; then ptr restarts at 7
        do_reset();
        req = 8'h04;
        tick();
        chk("mid.pre.idx", 32'(grant_idx), 32'd2);
        chk("mid.pre.vld", 32'(grant_vld), 32'd1);
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid.vld", 32'(grant_vld), 32'd0);
        chk("mid.oh",  32'(grant_oh),  32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        req   = 8'h80;
        tick();
        chk("post.vld", 32'(grant_vld), 32'd1);
        chk("post.idx", 32'(grant_idx), 32'd7);
        chk("post.oh",  32'(grant_oh),  32'h80);

        // Held request with no done: forced release only when the timeout is built in
        do_reset();
        req = 8'h04;
        if (TO_EN) begin
            pat_vld = 10'b11_1100_1111;
            pat_to  = 10'b00_0001_0000;
        end else begin
            pat_vld = 10'b11_1111_1111;
            pat_to  = 10'b00_0000_0000;
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("hold%0d.vld", c), 32'(grant_vld), 32'(pat_vld[c]));
            chk($sformatf("hold%0d.to", c),  32'(timeout),   32'(pat_to[c]));
            if (grant_vld) chk($sformatf("hold%0d.idx", c), 32'(grant_idx), 32'd2);
        end

        // Random traffic against the reference model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(2))
                    0:       req = 8'(1 << $urandom_range(7));
                    1:       req = 8'($urandom);
                    default: req = 8'($urandom) & 8'($urandom);
                endcase
            end
            done = ($urandom_range(4) == 0);
            tick();
            chk_model($sformatf("rnd%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
